serial_addsub_unit: RTL and testbench
=====================================

Name: serial_addsub_unit

Overview:
- Bit-serial, multi-cycle add/subtract engine with the same operand/select/result/carryOut semantics as the team's combinational AdderSubtractor.
- Acts as the responder on a valid/ready operation interface: it accepts one operation, computes one bit per clock (LSB first), then presents the result until the initiator takes it.
- Used where area matters more than latency, and as a cycle-accurate companion for checking the combinational unit.

Parameters:
- WIDTH, 8, operand/result width in bits; legal values 2..32.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  initiator has an operation on operandA/operandB/select.
- in_ready  output  1  unit can accept an operation (high only in IDLE).
- operandA  input  WIDTH  first operand.
- operandB  input  WIDTH  second operand.
- select  input  1  0 = add (A+B), 1 = subtract (A-B).
- out_valid  output  1  result/flags are valid and held stable.
- out_ready  input  1  initiator consumes the result.
- result  output  WIDTH  sum or difference, modulo 2^WIDTH.
- carryOut  output  1  carry out of the MSB; for subtract this is the no-borrow flag (1 when A >= B unsigned).
- overflow  output  1  two's-complement signed overflow.
- zero  output  1  result == 0.

Behaviour:
- Reset, asynchronous and active-high:
  - state = IDLE; in_ready = 1; out_valid = 0.
  - result, carryOut, overflow and zero all = 0; bit counter = 0.
  - Reset asserted mid-operation aborts that operation; no result is ever presented for it.
- States:
  - IDLE -> BUSY on the edge where in_valid & in_ready.
  - BUSY -> DONE after exactly WIDTH bit-cycles.
  - DONE -> IDLE on the edge where out_valid & out_ready.
- Accept edge:
  - Capture operandA into shift register SA.
  - Capture operandB XOR {WIDTH{select}} into SB.
  - Serial carry register c = select.
  - Capture select; clear the result shift register; counter = 0.
  - Operand inputs are don't-care after acceptance.
- BUSY, each edge:
  - s = SA[0] ^ SB[0] ^ c; c <= majority(SA[0], SB[0], c).
  - s is shifted into the result register MSB-first-in, so the result ends LSB-aligned after WIDTH shifts.
  - SA and SB shift right; counter increments.
  - On the edge where counter == WIDTH-1:
    - Transition to DONE and set out_valid = 1.
    - carryOut = final carry.
    - overflow = carry into the MSB XOR carry out of the MSB; keep the previous carry for this.
    - zero = (full result == 0).
- Latency: out_valid rises exactly WIDTH clock edges after the accept edge (8 for the default). Throughput is one operation per WIDTH+2 cycles when out_ready is held high.
- DONE:
  - result and flags are held stable while out_valid = 1 and out_ready = 0, for any number of cycles.
  - in_ready = 0; in_valid is ignored.
  - On the handshake edge, out_valid drops and in_ready rises the following cycle. Result and flags keep their last values; they are only qualified by out_valid.
- Simultaneous events:
  - in_valid is never accepted in the same cycle as the output handshake, because in_ready is low in DONE.
  - out_ready asserted while not out_valid has no effect.
  - in_valid held high continuously causes back-to-back operations at the throughput above.
- Arithmetic:
  - Everything is modulo 2^WIDTH.
  - Subtract is A + ~B + 1.
  - carryOut is identical to bit WIDTH of the {1'b0,A} +/- {1'b0,B} extended computation in the combinational unit's convention (add: carry; sub: no-borrow).

Test Plan:
- Reset, then 0xAA + 0x55 (select=0) -> out_valid exactly 8 edges after accept; result 0xFF, carryOut 0, overflow 0, zero 0.
- 0x70 - 0x01 -> 0x6F, carryOut 1, overflow 0.
- 31 - 31 -> 0x00, carryOut 1, zero 1.
- 67 - 45 -> 22; 98 - 31 -> 67; 0xF0 - 0x0F -> 0xE1, carryOut 1, overflow 0.
- Flag corners: 0x7F + 0x01 -> 0x80, overflow 1, carryOut 0. 0x01 - 0x02 -> 0xFF, carryOut 0 (borrow). 0x80 - 0x01 -> 0x7F, overflow 1.
- Handshake:
  - Hold out_ready low 5 cycles in DONE -> result stable, in_ready 0, new in_valid ignored.
  - Release out_ready -> next op accepted one cycle later.
  - Assert rst at BUSY cycle 4 -> all outputs return to reset values immediately; the next op computes correctly.

Source files
------------

// File: rtl/serial_addsub_unit.sv
// Bit-serial add/subtract engine with a valid/ready handshake on both sides.
// One operand bit is processed per clock, LSB first. The result and flags are
// held until the initiator consumes them.
module serial_addsub_unit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic             select,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryOut,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} stateT;

    stateT            stateQ, stateD;
    logic [WIDTH-1:0] shiftAQ, shiftAD;
    logic [WIDTH-1:0] shiftBQ, shiftBD;
    logic [WIDTH-1:0] resultQ, resultD;
    logic [CntW-1:0]  countQ, countD;
    logic             carryQ, carryD;
    logic             carryOutQ, carryOutD;
    logic             overflowQ, overflowD;
    logic             zeroQ, zeroD;
    logic             sumBit;
    logic             carryNext;

    // State register and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ    <= StIdle;
            shiftAQ   <= '0;
            shiftBQ   <= '0;
            resultQ   <= '0;
            countQ    <= '0;
            carryQ    <= 1'b0;
            carryOutQ <= 1'b0;
            overflowQ <= 1'b0;
            zeroQ     <= 1'b0;
        end else begin
            stateQ    <= stateD;
            shiftAQ   <= shiftAD;
            shiftBQ   <= shiftBD;
            resultQ   <= resultD;
            countQ    <= countD;
            carryQ    <= carryD;
            carryOutQ <= carryOutD;
            overflowQ <= overflowD;
            zeroQ     <= zeroD;
        end
    end

    // Next-state logic: accept, one full-adder step per BUSY cycle, hold in DONE.
    always_comb begin
        stateD    = stateQ;
        shiftAD   = shiftAQ;
        shiftBD   = shiftBQ;
        resultD   = resultQ;
        countD    = countQ;
        carryD    = carryQ;
        carryOutD = carryOutQ;
        overflowD = overflowQ;
        zeroD     = zeroQ;

        sumBit    = shiftAQ[0] ^ shiftBQ[0] ^ carryQ;
        carryNext = (shiftAQ[0] & shiftBQ[0]) | (shiftAQ[0] & carryQ) | (shiftBQ[0] & carryQ);

        unique case (stateQ)
            StIdle: begin
                if (in_valid) begin
                    stateD  = StBusy;
                    shiftAD = operandA;
                    // Subtract as A + ~B + 1: invert B here, seed the carry with 1.
                    shiftBD = operandB ^ {WIDTH{select}};
                    carryD  = select;
                    resultD = '0;
                    countD  = '0;
                end
            end
            StBusy: begin
                resultD = {sumBit, resultQ[WIDTH-1:1]};
                shiftAD = shiftAQ >> 1;
                shiftBD = shiftBQ >> 1;
                carryD  = carryNext;
                countD  = countQ + CntW'(1);
                if (countQ == LastBit) begin
                    stateD    = StDone;
                    carryOutD = carryNext;
                    // carryQ is the carry into the MSB on this last step.
                    overflowD = carryQ ^ carryNext;
                    zeroD     = (resultD == '0);
                end
            end
            StDone: begin
                if (out_ready) begin
                    stateD = StIdle;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    assign in_ready  = (stateQ == StIdle);
    assign out_valid = (stateQ == StDone);
    assign result    = resultQ;
    assign carryOut  = carryOutQ;
    assign overflow  = overflowQ;
    assign zero      = zeroQ;

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Self-checking bench for serial_addsub_unit: an arithmetic reference model
// with per-cycle comparison, directed corner cases, handshake and reset tests.
module tb_serial_addsub_unit;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
        logic         z;
    } expT;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] operandA;
    logic [W-1:0] operandB;
    logic         select;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carryOut;
    logic         overflow;
    logic         zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_addsub_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .operandA (operandA),
        .operandB (operandB),
        .select   (select),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .carryOut (carryOut),
        .overflow (overflow),
        .zero     (zero)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic from plain integer semantics.
    function automatic expT refCalc(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic sel);
        expT    e;
        longint ua, ub, sa, sb, t, lim;
        ua  = longint'(a);
        ub  = longint'(b);
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        lim = longint'(1) <<< (W - 1);
        t   = sel ? (sa - sb) : (sa + sb);
        e.res = sel ? (a - b) : (a + b);
        e.co  = sel ? (ua >= ub) : ((ua + ub) >= (longint'(1) <<< W));
        e.ov  = (t >= lim) || (t < -lim);
        e.z   = (e.res == '0);
        return e;
    endfunction

    // Transaction-level model: idle / busy for W edges / done until consumed.
    int  mPhase;
    int  mLeft;
    expT mPend;
    expT mOut;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mPhase <= 0;
            mLeft  <= 0;
            mOut   <= '0;
        end else begin
            case (mPhase)
                0: if (in_valid) begin
                    mPhase <= 1;
                    mLeft  <= W;
                    mPend  <= refCalc(operandA, operandB, select);
                end
                1: if (mLeft == 1) begin
                    mPhase <= 2;
                    mOut   <= mPend;
                end else begin
                    mLeft <= mLeft - 1;
                end
                2: if (out_ready) mPhase <= 0;
                default: mPhase <= 0;
            endcase
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("cyc in_ready", in_ready, mPhase == 0);
            check("cyc out_valid", out_valid, mPhase == 2);
            if (mPhase == 2) begin
                check("cyc result", result, mOut.res);
                check("cyc carryOut", carryOut, mOut.co);
                check("cyc overflow", overflow, mOut.ov);
                check("cyc zero", zero, mOut.z);
            end
        end
    end

    // One operation: accept, measure latency, hold in DONE, then consume.
    task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic sel,
                         input int hold, output expT got);
        int n;
        int lat;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        operandA = a;
        operandB = b;
        select   = sel;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        operandA = W'($urandom);
        operandB = W'($urandom);
        select   = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, W);
        got = {result, carryOut, overflow, zero};
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            operandA = W'($urandom);
            operandB = W'($urandom);
            @(posedge clk);
            #1;
            check("hold result", result, got.res);
            check("hold flags", {carryOut, overflow, zero}, {got.co, got.ov, got.z});
            check("hold in_ready", in_ready, 1'b0);
            check("hold out_valid", out_valid, 1'b1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("post handshake out_valid", out_valid, 1'b0);
        check("post handshake in_ready", in_ready, 1'b1);
    endtask

    task automatic dirOp(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sel, input int hold, input logic [W-1:0] eRes,
                         input logic eCo, input logic eOv, input logic eZ);
        expT got;
        runOp(a, b, sel, hold, got);
        check($sformatf("%s result", name), got.res, eRes);
        check($sformatf("%s carryOut", name), got.co, eCo);
        check($sformatf("%s overflow", name), got.ov, eOv);
        check($sformatf("%s zero", name), got.z, eZ);
    endtask

    initial begin
        int  r1;
        int  r2;
        int  n;
        logic prev;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        operandA  = '0;
        operandB  = '0;
        select    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", in_ready, 1'b1);
        check("reset out_valid", out_valid, 1'b0);
        check("reset result", result, 0);
        check("reset flags", {carryOut, overflow, zero}, 3'b000);
        rst = 1'b0;

        dirOp("AA+55", 8'hAA, 8'h55, 1'b0, 0, 8'hFF, 1'b0, 1'b0, 1'b0);
        dirOp("70-01", 8'h70, 8'h01, 1'b1, 0, 8'h6F, 1'b1, 1'b0, 1'b0);
        dirOp("31-31", 8'd31, 8'd31, 1'b1, 0, 8'h00, 1'b1, 1'b0, 1'b1);
        dirOp("67-45", 8'd67, 8'd45, 1'b1, 0, 8'd22, 1'b1, 1'b0, 1'b0);
        dirOp("98-31", 8'd98, 8'd31, 1'b1, 0, 8'd67, 1'b1, 1'b0, 1'b0);
        dirOp("F0-0F", 8'hF0, 8'h0F, 1'b1, 0, 8'hE1, 1'b1, 1'b0, 1'b0);
        dirOp("7F+01", 8'h7F, 8'h01, 1'b0, 0, 8'h80, 1'b0, 1'b1, 1'b0);
        dirOp("01-02", 8'h01, 8'h02, 1'b1, 0, 8'hFF, 1'b0, 1'b0, 1'b0);
        dirOp("80-01", 8'h80, 8'h01, 1'b1, 0, 8'h7F, 1'b1, 1'b1, 1'b0);
        dirOp("hold C3+3D", 8'hC3, 8'h3D, 1'b0, 5, 8'h00, 1'b1, 1'b0, 1'b1);

        // Abort an operation in BUSY cycle 4 with an asynchronous reset.
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        operandA = 8'h12;
        operandB = 8'h34;
        select   = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort in_ready", in_ready, 1'b1);
        check("abort out_valid", out_valid, 1'b0);
        check("abort result", result, 0);
        check("abort flags", {carryOut, overflow, zero}, 3'b000);
        @(posedge clk);
        #2;
        rst = 1'b0;
        dirOp("after abort 67-45", 8'd67, 8'd45, 1'b1, 0, 8'd22, 1'b1, 1'b0, 1'b0);

        // Random traffic on both sides; the model checks every cycle.
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            in_valid  = 1'($urandom_range(0, 1));
            operandA  = W'($urandom);
            operandB  = W'($urandom);
            select    = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
        end

        // Back-to-back streaming: result period must be W+2 cycles.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        r1   = -1;
        r2   = -1;
        prev = out_valid;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            operandA = W'($urandom);
            operandB = W'($urandom);
            select   = 1'($urandom);
            if (out_valid && !prev) begin
                if (r1 < 0) r1 = k;
                else if (r2 < 0) r2 = k;
            end
            prev = out_valid;
        end
        check("throughput period", r2 - r1, W + 2);

        in_valid = 1'b0;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain to idle", in_ready, 1'b1);
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
